// File: rtl/ser_load_counter_pkg.sv
// ser_load_counter_pkg
// Shared definitions for the serial-load up/down counter block:
//   mode_e        - overflow behaviour selector (modular wrap or saturate)
//   WIDTH_DEFAULT - default counter / shift register width
package ser_load_counter_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  localparam int WIDTH_DEFAULT = 8;

endpackage

// File: rtl/ser_load_counter_sync_edge_det.sv
// sync_edge_det
// Two-flop synchroniser for an asynchronous input followed by a rising-edge
// detector running in the clk domain.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset, clears all stages to 0
//   d    - asynchronous input
//   rise - one-clk pulse when the synchronised input goes 0 -> 1
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic meta;
  logic sync_now;
  logic sync_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta      <= 1'b0;
      sync_now  <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      meta      <= d;
      sync_now  <= meta;
      sync_prev <= sync_now;
    end
  end

  assign rise = sync_now & ~sync_prev;

endmodule

// File: rtl/ser_load_counter.sv
// ser_load_counter
// Up/down counter that can be parallel-loaded from a serially filled shift
// register. The serial port (sdi/sclk) is asynchronous to clk and is
// oversampled; sclk is only ever used as data.
// Parameters:
//   WIDTH - counter and shift register width (2..32)
//   MODE  - MODE_WRAP (modular) or MODE_SAT (saturating) overflow
// Ports:
//   clk, rst   - system clock, asynchronous active-high reset
//   ena        - enables the counter path (load and count)
//   load       - request to copy a full frame into the counter
//   en, up     - count enable and direction (1 = increment)
//   oe         - gates count_out (zeros when low)
//   sdi, sclk  - serial data and serial clock, MSB first
//   count_out  - counter value or zeros
//   tc         - terminal count for the current direction
//   frame_full - WIDTH bits received since the last accepted load
//   load_err   - one-cycle pulse when a load arrives before a full frame
module ser_load_counter
  import ser_load_counter_pkg::*;
#(
  parameter int    WIDTH = WIDTH_DEFAULT,
  parameter mode_e MODE  = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             load,
  input  logic             en,
  input  logic             up,
  input  logic             oe,
  input  logic             sdi,
  input  logic             sclk,
  output logic [WIDTH-1:0] count_out,
  output logic             tc,
  output logic             frame_full,
  output logic             load_err
);

  localparam int               BCW       = $clog2(WIDTH + 1);
  localparam logic [BCW-1:0]   BITS_FULL = BCW'(WIDTH);
  localparam logic [WIDTH-1:0] CNT_MAX   = {WIDTH{1'b1}};

  logic             sdi_meta;
  logic             sdi_sync;
  logic             sclk_rise;
  logic [WIDTH-1:0] shreg;
  logic [BCW-1:0]   bit_cnt;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_nxt;
  logic             load_ok;
  logic             load_rej;

  // sdi only needs to be stable around the sclk edge, so a plain two-flop
  // synchroniser keeps it aligned with the sclk edge detector below.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sdi_meta <= 1'b0;
      sdi_sync <= 1'b0;
    end else begin
      sdi_meta <= sdi;
      sdi_sync <= sdi_meta;
    end
  end

  sync_edge_det u_sclk_det (
    .clk  (clk),
    .rst  (rst),
    .d    (sclk),
    .rise (sclk_rise)
  );

  assign frame_full = (bit_cnt == BITS_FULL);
  assign load_ok    = ena & load & frame_full;
  assign load_rej   = ena & load & ~frame_full;

  // The shift path ignores ena; once full it keeps the most recent WIDTH bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
    end else if (sclk_rise) begin
      shreg <= {shreg[WIDTH-2:0], sdi_sync};
    end
  end

  // A load that coincides with a shift copies the old register contents,
  // so the incoming bit is the first bit of the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
    end else if (load_ok) begin
      bit_cnt <= sclk_rise ? BCW'(1) : '0;
    end else if (sclk_rise && !frame_full) begin
      bit_cnt <= bit_cnt + BCW'(1);
    end
  end

  // Any load request, accepted or not, takes priority over counting.
  always_comb begin
    count_nxt = count;
    if (ena) begin
      if (load) begin
        if (frame_full) begin
          count_nxt = shreg;
        end
      end else if (en) begin
        if (up) begin
          if (count == CNT_MAX) begin
            count_nxt = (MODE == MODE_SAT) ? CNT_MAX : '0;
          end else begin
            count_nxt = count + WIDTH'(1);
          end
        end else begin
          if (count == '0) begin
            count_nxt = (MODE == MODE_SAT) ? '0 : CNT_MAX;
          end else begin
            count_nxt = count - WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      load_err <= 1'b0;
    end else begin
      count    <= count_nxt;
      load_err <= load_rej;
    end
  end

  assign tc        = up ? (count == CNT_MAX) : (count == '0);
  assign count_out = oe ? count : '0;

endmodule

// File: tb/tb_ser_load_counter.sv
// tb_ser_load_counter
// Drives one wrapping and one saturating 8-bit instance from the same inputs
// and compares both against a behavioural model on every falling clk edge,
// plus explicit checks on the directed scenarios.
module tb_ser_load_counter;
  import ser_load_counter_pkg::*;

  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic ena  = 1'b0;
  logic load = 1'b0;
  logic en   = 1'b0;
  logic up   = 1'b0;
  logic oe   = 1'b1;
  logic sdi  = 1'b0;
  logic sclk = 1'b0;

  logic [7:0] cnt_w, cnt_s;
  logic       tc_w, tc_s, ff_w, ff_s, err_w, err_s;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit rand_ctrl = 1'b0;
  bit chk_en    = 1'b0;

  // Pending shifts: the clk edge number at which each serial bit lands.
  typedef struct {
    int due;
    bit b;
  } shift_t;
  shift_t sq[$];

  // Model state: counters for both modes, received bits, frame bit count.
  int m_cw   = 0;
  int m_cs   = 0;
  int m_sh   = 0;
  int m_bits = 0;
  bit m_err  = 1'b0;

  ser_load_counter #(.WIDTH(8), .MODE(MODE_WRAP)) dut_wrap (
    .clk(clk), .rst(rst), .ena(ena), .load(load), .en(en), .up(up), .oe(oe),
    .sdi(sdi), .sclk(sclk), .count_out(cnt_w), .tc(tc_w),
    .frame_full(ff_w), .load_err(err_w)
  );

  ser_load_counter #(.WIDTH(8), .MODE(MODE_SAT)) dut_sat (
    .clk(clk), .rst(rst), .ena(ena), .load(load), .en(en), .up(up), .oe(oe),
    .sdi(sdi), .sclk(sclk), .count_out(cnt_s), .tc(tc_s),
    .frame_full(ff_s), .load_err(err_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int stepCount(input int c, input bit sat, input bit dir_up);
    if (dir_up) return (c == 255) ? (sat ? 255 : 0) : c + 1;
    else        return (c == 0)   ? (sat ? 0 : 255) : c - 1;
  endfunction

  function automatic bit shiftDue();
    return (sq.size() > 0) && (sq[0].due == cyc + 1);
  endfunction

  // Behavioural reference, evaluated at every rising clk edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cw   <= 0;
      m_cs   <= 0;
      m_sh   <= 0;
      m_bits <= 0;
      m_err  <= 1'b0;
      sq.delete();
    end else begin
      if (ena && load) begin
        if (m_bits == 8) begin
          m_cw <= m_sh;
          m_cs <= m_sh;
        end
        m_err <= (m_bits != 8);
      end else begin
        m_err <= 1'b0;
        if (ena && en) begin
          m_cw <= stepCount(m_cw, 1'b0, up);
          m_cs <= stepCount(m_cs, 1'b1, up);
        end
      end
      if (shiftDue()) begin
        m_sh   <= (m_sh * 2 + int'(sq[0].b)) % 256;
        m_bits <= (ena && load && m_bits == 8) ? 1 : ((m_bits == 8) ? 8 : m_bits + 1);
        void'(sq.pop_front());
      end else if (ena && load && m_bits == 8) begin
        m_bits <= 0;
      end
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("cnt_w", 32'(cnt_w), oe ? m_cw : 0);
      checkOutput("cnt_s", 32'(cnt_s), oe ? m_cs : 0);
      checkOutput("tc_w",  32'(tc_w),  32'(up ? (m_cw == 255) : (m_cw == 0)));
      checkOutput("tc_s",  32'(tc_s),  32'(up ? (m_cs == 255) : (m_cs == 0)));
      checkOutput("ff_w",  32'(ff_w),  32'(m_bits == 8));
      checkOutput("ff_s",  32'(ff_s),  32'(m_bits == 8));
      checkOutput("err_w", 32'(err_w), 32'(m_err));
      checkOutput("err_s", 32'(err_s), 32'(m_err));
    end
  end

  // Advance to just after the next rising edge; optionally randomise controls.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ctrl) begin
      ena  = ($urandom_range(0, 3) != 0);
      load = ($urandom_range(0, 9) == 0);
      en   = ($urandom_range(0, 1) == 1);
      up   = ($urandom_range(0, 1) == 1);
      oe   = ($urandom_range(0, 4) != 0);
    end
  endtask

  // One serial bit: 4 clk high, 4 clk low. The bit lands 3 edges after sclk
  // rises; with load_at_shift the load request is timed onto that edge.
  task automatic applyStimulus(input bit b, input bit load_at_shift);
    sdi  = b;
    sclk = 1'b1;
    sq.push_back('{cyc + 3, b});
    if (load_at_shift) begin
      repeat (2) tick();
      load = 1'b1;
      tick();
      load = 1'b0;
      tick();
    end else begin
      repeat (4) tick();
    end
    sclk = 1'b0;
    repeat (4) tick();
  endtask

  task automatic shiftByte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) applyStimulus(v[i], 1'b0);
  endtask

  task automatic pulseLoad();
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    chk_en = 1'b1;
    checkOutput("rst_cnt", 32'(cnt_w), 32'h0);
    checkOutput("rst_tc_dn", 32'(tc_w), 32'h1);
    checkOutput("rst_ff", 32'(ff_s), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    up  = 1'b1;
    ena = 1'b1;
    tick();

    // Full frame 0xA5 then load
    shiftByte(8'hA5);
    checkOutput("a5_full", 32'(ff_w), 32'h1);
    pulseLoad();
    checkOutput("a5_cnt", 32'(cnt_w), 32'hA5);
    checkOutput("a5_ffclr", 32'(ff_w), 32'h0);

    // Premature load after 5 bits, then complete frame 0xC3
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    pulseLoad();
    checkOutput("early_err", 32'(err_w), 32'h1);
    checkOutput("early_hold", 32'(cnt_w), 32'hA5);
    tick();
    checkOutput("early_err1", 32'(err_w), 32'h0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    pulseLoad();
    checkOutput("c3_cnt", 32'(cnt_w), 32'hC3);

    // Overflow at 0xFF and underflow at 0x00
    shiftByte(8'hFF);
    pulseLoad();
    checkOutput("ff_tc", 32'(tc_w), 32'h1);
    en = 1'b1;
    tick();
    en = 1'b0;
    checkOutput("wrap_up", 32'(cnt_w), 32'h00);
    checkOutput("sat_up", 32'(cnt_s), 32'hFF);
    up = 1'b0;
    en = 1'b1;
    tick();
    en = 1'b0;
    checkOutput("wrap_dn", 32'(cnt_w), 32'hFF);
    checkOutput("sat_dn", 32'(cnt_s), 32'hFE);
    up = 1'b1;

    // Saturate up from 0xFE for 3 cycles
    shiftByte(8'hFE);
    pulseLoad();
    en = 1'b1;
    tick();
    checkOutput("fe_s1", 32'(cnt_s), 32'hFF);
    tick();
    checkOutput("fe_s2", 32'(cnt_s), 32'hFF);
    checkOutput("fe_w2", 32'(cnt_w), 32'h00);
    tick();
    checkOutput("fe_s3", 32'(cnt_s), 32'hFF);
    checkOutput("fe_w3", 32'(cnt_w), 32'h01);
    en = 1'b0;

    // Saturate down from 0x01
    shiftByte(8'h01);
    pulseLoad();
    up = 1'b0;
    en = 1'b1;
    tick();
    checkOutput("01_s1", 32'(cnt_s), 32'h00);
    tick();
    checkOutput("01_s2", 32'(cnt_s), 32'h00);
    checkOutput("01_w2", 32'(cnt_w), 32'hFF);
    en = 1'b0;
    up = 1'b1;

    // Load coincident with the 9th shift edge, then ena=0 ignores load
    shiftByte(8'h5A);
    applyStimulus(1'b1, 1'b1);
    checkOutput("coin_cnt", 32'(cnt_w), 32'h5A);
    checkOutput("coin_ff", 32'(ff_w), 32'h0);
    ena  = 1'b0;
    load = 1'b1;
    repeat (3) tick();
    checkOutput("dis_err", 32'(err_w), 32'h0);
    checkOutput("dis_cnt", 32'(cnt_s), 32'h5A);
    load = 1'b0;
    ena  = 1'b1;

    // Reset mid-frame, then a fresh frame 0x3C
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    up  = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_cnt", 32'(cnt_w), 32'h0);
    checkOutput("mid_rst_ff", 32'(ff_w), 32'h0);
    checkOutput("mid_rst_err", 32'(err_w), 32'h0);
    checkOutput("mid_rst_tc", 32'(tc_s), 32'h1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    up  = 1'b1;
    tick();
    shiftByte(8'h3C);
    pulseLoad();
    checkOutput("3c_oe1", 32'(cnt_w), 32'h3C);
    oe = 1'b0;
    #1;
    checkOutput("3c_oe0", 32'(cnt_w), 32'h00);
    oe = 1'b1;
    tick();

    // Randomised traffic: random frame lengths and random control lines
    rand_ctrl = 1'b1;
    for (int f = 0; f < 25; f++) begin
      int nb;
      nb = $urandom_range(1, 12);
      for (int i = 0; i < nb; i++) applyStimulus($urandom_range(0, 1) == 1, 1'b0);
    end
    rand_ctrl = 1'b0;
    load = 1'b0;
    repeat (6) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
